mac_sequencer: RTL

MAC_SEQUENCER -- requirements
Module: mac_sequencer

---
 rtl/mac_sequencer_pkg.sv | 17 +
 rtl/mac_operand_bank.sv | 37 +++
 rtl/mac_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mac_sequencer_pkg.sv
// Shared types and sizing for the 4x4 matrix-multiply MAC sequencer.
package mac_sequencer_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DIM    = 4;
    localparam int unsigned ACC_W  = 16;
    localparam int unsigned ELEMS  = DIM * DIM;
    localparam int unsigned ADDR_W = $clog2(ELEMS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_CAPTURE,
        S_DONE
    } state_e;

endpackage

// File: rtl/mac_operand_bank.sv
// Operand storage for matrices A and B: one write port, one combinational read port per matrix.
module mac_operand_bank
    import mac_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_a_addr,
    output logic [DATA_W-1:0] rd_a_data,
    input  logic [ADDR_W-1:0] rd_b_addr,
    output logic [DATA_W-1:0] rd_b_data
);

    logic [DATA_W-1:0] mem_a [ELEMS];
    logic [DATA_W-1:0] mem_b [ELEMS];

    // Element write; wr_sel picks B (1) or A (0). Reset clears both matrices.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_a <= '{default: '0};
            mem_b <= '{default: '0};
        end else if (wr_en) begin
            if (wr_sel) begin
                mem_b[wr_addr] <= wr_data;
            end else begin
                mem_a[wr_addr] <= wr_data;
            end
        end
    end

    assign rd_a_data = mem_a[rd_a_addr];
    assign rd_b_data = mem_b[rd_b_addr];

endmodule

// File: rtl/mac_sequencer.sv
// Sequences a 4x4 matrix multiply C = A x B through an external MAC, one element per 5 cycles.
module mac_sequencer
    import mac_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIM    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic              load_sel,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              start,
    output logic              busy,
    output logic              mac_en,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    input  logic [ACC_W-1:0]  mac_result,
    output logic              res_valid,
    output logic [ADDR_W-1:0] res_idx,
    output logic [ACC_W-1:0]  res_data,
    output logic              done
);

    localparam int unsigned        IDX_W = $clog2(DIM);
    localparam logic [IDX_W-1:0]   LAST  = IDX_W'(DIM - 1);

    state_e            state;
    logic [IDX_W-1:0]  i, j, k;
    logic [IDX_W-1:0]  n_i, n_j, n_k;
    logic [ADDR_W-1:0] rd_a_addr, rd_b_addr;
    logic [DATA_W-1:0] rd_a_data, rd_b_data;
    logic [DATA_W-1:0] op_a_c, op_b_c;
    logic              wr_en;

    assign wr_en = (state == S_IDLE) && load_valid;

    mac_operand_bank u_bank (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_sel    (load_sel),
        .wr_addr   (load_addr),
        .wr_data   (load_data),
        .rd_a_addr (rd_a_addr),
        .rd_a_data (rd_a_data),
        .rd_b_addr (rd_b_addr),
        .rd_b_data (rd_b_data)
    );

    // Indices of the operand pair presented in the next cycle; the bank is read ahead so mac_a/mac_b can be registered.
    always_comb begin
        n_i = i;
        n_j = j;
        n_k = k;
        case (state)
            S_IDLE: begin
                n_i = '0;
                n_j = '0;
                n_k = '0;
            end
            S_FEED: begin
                n_k = k + IDX_W'(1);
            end
            S_CAPTURE: begin
                n_k = '0;
                if (j == LAST) begin
                    n_j = '0;
                    n_i = i + IDX_W'(1);
                end else begin
                    n_j = j + IDX_W'(1);
                end
            end
            default: ;
        endcase
        rd_a_addr = ADDR_W'({n_i, n_k});
        rd_b_addr = ADDR_W'({n_k, n_j});
    end

    // Forward a write landing in the same cycle as start, so the first FEED sees the new value.
    always_comb begin
        op_a_c = rd_a_data;
        op_b_c = rd_b_data;
        if (wr_en && !load_sel && (load_addr == rd_a_addr)) begin
            op_a_c = load_data;
        end
        if (wr_en && load_sel && (load_addr == rd_b_addr)) begin
            op_b_c = load_data;
        end
    end

    // Sequencer state, indices and registered outputs; pulses and MAC drive default low each cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            i          <= '0;
            j          <= '0;
            k          <= '0;
            load_ready <= 1'b1;
            busy       <= 1'b0;
            mac_en     <= 1'b0;
            mac_a      <= '0;
            mac_b      <= '0;
            res_valid  <= 1'b0;
            res_idx    <= '0;
            res_data   <= '0;
            done       <= 1'b0;
        end else begin
            mac_en    <= 1'b0;
            mac_a     <= '0;
            mac_b     <= '0;
            res_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    load_ready <= 1'b1;
                    busy       <= 1'b0;
                    if (start) begin
                        state      <= S_FEED;
                        i          <= '0;
                        j          <= '0;
                        k          <= '0;
                        load_ready <= 1'b0;
                        busy       <= 1'b1;
                        mac_en     <= 1'b1;
                        mac_a      <= op_a_c;
                        mac_b      <= op_b_c;
                    end
                end
                S_FEED: begin
                    if (k == LAST) begin
                        state <= S_CAPTURE;
                    end else begin
                        k      <= n_k;
                        mac_en <= 1'b1;
                        mac_a  <= op_a_c;
                        mac_b  <= op_b_c;
                    end
                end
                S_CAPTURE: begin
                    res_data  <= mac_result;
                    res_idx   <= ADDR_W'({i, j});
                    res_valid <= 1'b1;
                    if ((i == LAST) && (j == LAST)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state  <= S_FEED;
                        i      <= n_i;
                        j      <= n_j;
                        k      <= '0;
                        mac_en <= 1'b1;
                        mac_a  <= op_a_c;
                        mac_b  <= op_b_c;
                    end
                end
                S_DONE: begin
                    state      <= S_IDLE;
                    i          <= '0;
                    j          <= '0;
                    k          <= '0;
                    busy       <= 1'b0;
                    load_ready <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
